// File: rtl/quad_pkg.sv
// Shared types and helpers for the sum-of-squares power path.
package quad_pkg;

   localparam int DATA_W    = 29;
   localparam int INT_W     = 5;
   localparam int FRAC_W    = 24;
   localparam int IN_W      = 14;
   localparam int IN_FRAC_W = 12;

   typedef logic unsigned [DATA_W-1:0] qpow_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   function automatic qpow_t max_q(input qpow_t a, input qpow_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/quad_fwl_trunc.sv
// Fixed-point fractional word-length truncation: keeps FWL of FRAC fraction bits.
// Latency: combinational.
// Backpressure: none, pure datapath.
module quad_fwl_trunc #(
   parameter int W    = 29,
   parameter int FRAC = 24,
   parameter int FWL  = 24
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   generate
      if (FWL == FRAC) begin : g_pass
         assign dout = din;
      end else begin : g_trunc
         // Mask form keeps every input bit referenced; dropped bits read as zero.
         localparam logic [W-1:0] KEEP_MASK = ~((W'(1) << (FRAC - FWL)) - W'(1));
         assign dout = din & KEEP_MASK;
      end
   endgenerate

endmodule

// File: rtl/quad_mean.sv
// Window mean/peak of Q5.24 power samples over 2^LOG2_N samples.
// Latency: result registered one edge after the final sample is accepted.
// Backpressure: only the final sample of a window stalls, while a result is held.
module quad_mean
   import quad_pkg::*;
#(
   parameter int LOG2_N = 2,
   parameter int FWL_O  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_mean,
   output logic [DATA_W-1:0] out_peak
);

   localparam int N     = 1 << LOG2_N;
   localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
   localparam int ACC_W = DATA_W + LOG2_N;

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   qpow_t            peak;

   logic             last;
   logic             accept;
   logic             final_acc;
   logic [ACC_W-1:0] sum;
   qpow_t            mean;
   qpow_t            mean_q;
   qpow_t            peak_nxt;

   out_state_t       state;
   out_state_t       state_nxt;
   logic             load_res;

   assign last      = (cnt == CNT_W'(N - 1));
   // in_ready depends combinationally on out_ready: a held result freed this
   // cycle lets the next window's final sample in without a bubble.
   assign in_ready  = !rst && !clr && (!last || !out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign final_acc = accept && last;

   assign sum      = acc + ACC_W'(in_data);
   assign mean     = DATA_W'(sum >> LOG2_N);
   assign peak_nxt = max_q(peak, qpow_t'(in_data));

   quad_fwl_trunc #(
      .W    (DATA_W),
      .FRAC (FRAC_W),
      .FWL  (FWL_O)
   ) u_trunc (
      .din  (mean),
      .dout (mean_q)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc  <= '0;
         cnt  <= '0;
         peak <= '0;
      end else if (accept) begin
         if (last) begin
            acc  <= '0;
            cnt  <= '0;
            peak <= '0;
         end else begin
            acc  <= sum;
            cnt  <= cnt + CNT_W'(1);
            peak <= peak_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OUT_EMPTY: if (final_acc) state_nxt = OUT_FULL;
         OUT_FULL:  if (out_ready && !final_acc) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state == OUT_FULL);
      load_res  = final_acc;
   end

   // final_acc cannot fire while a result is held unconsumed, so the
   // result register only reloads when its contents are free to go.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_mean <= '0;
         out_peak <= '0;
      end else if (load_res) begin
         out_mean <= mean_q;
         out_peak <= peak_nxt;
      end
   end

endmodule

// File: tb/tb_quad_mean.sv
// Directed bench for quad_mean: 4-sample window instance and a 1-sample FWL_O=4 instance.
module tb_quad_mean;
   import quad_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              a_clr = 1'b0, a_valid = 1'b0, a_out_ready = 1'b0;
   logic [DATA_W-1:0] a_data = '0;
   logic              a_in_ready, a_out_valid;
   logic [DATA_W-1:0] a_mean, a_peak;

   logic              b_clr = 1'b0, b_valid = 1'b0, b_out_ready = 1'b0;
   logic [DATA_W-1:0] b_data = '0;
   logic              b_in_ready, b_out_valid;
   logic [DATA_W-1:0] b_mean, b_peak;

   int total  = 0;
   int passed = 0;

   quad_mean #(.LOG2_N(2), .FWL_O(24)) u_a (
      .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in_ready(a_in_ready),
      .in_data(a_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_mean(a_mean), .out_peak(a_peak)
   );

   quad_mean #(.LOG2_N(0), .FWL_O(4)) u_b (
      .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_valid), .in_ready(b_in_ready),
      .in_data(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_mean(b_mean), .out_peak(b_peak)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample on instance A and return just after the edge that takes it.
   task automatic send_a(input logic [DATA_W-1:0] d);
      int k;
      a_valid = 1'b1;
      a_data  = d;
      #1;
      k = 0;
      while (!a_in_ready && k < 50) begin
         tick();
         k++;
      end
      if (!a_in_ready) chk("send_a_timeout", 32'(a_in_ready), 32'd1);
      tick();
   endtask

   initial begin
      // Reset
      tick();
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_mean", 32'(a_mean), 32'd0);
      chk("rst_out_peak", 32'(a_peak), 32'd0);
      chk("rst_in_ready_after", 32'(a_in_ready), 32'd1);

      // LOG2_N=0, FWL_O=4: every sample is final; 20 low fraction bits cleared
      b_out_ready = 1'b1;
      b_valid = 1'b1;
      b_data  = 29'h1234567;
      tick();
      b_valid = 1'b0;
      chk("b_valid", 32'(b_out_valid), 32'd1);
      chk("b_mean", 32'(b_mean), 32'h1200000);
      chk("b_peak", 32'(b_peak), 32'h1234567);
      tick();
      chk("b_consumed", 32'(b_out_valid), 32'd0);

      // Ramp window 1,2,3,4 -> mean 2.5
      a_out_ready = 1'b1;
      send_a(29'h1000000);
      send_a(29'h2000000);
      send_a(29'h3000000);
      chk("ramp_not_yet", 32'(a_out_valid), 32'd0);
      send_a(29'h4000000);
      a_valid = 1'b0;
      chk("ramp_valid", 32'(a_out_valid), 32'd1);
      chk("ramp_mean", 32'(a_mean), 32'h2800000);
      chk("ramp_peak", 32'(a_peak), 32'h4000000);
      tick();
      chk("ramp_consumed", 32'(a_out_valid), 32'd0);

      // Held output: 8 samples with consumer stalled
      a_out_ready = 1'b0;
      for (int i = 0; i < 7; i++) send_a(29'h1000000);
      a_valid = 1'b1;
      a_data  = 29'h1000000;
      #1;
      chk("hold_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      tick();
      tick();
      chk("hold_in_ready_later", 32'(a_in_ready), 32'd0);
      chk("hold_valid", 32'(a_out_valid), 32'd1);
      chk("hold_mean", 32'(a_mean), 32'h1000000);
      chk("hold_peak", 32'(a_peak), 32'h1000000);
      a_out_ready = 1'b1;
      #1;
      chk("hold_release_ready", 32'(a_in_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      chk("b2b_valid", 32'(a_out_valid), 32'd1);
      chk("b2b_mean", 32'(a_mean), 32'h1000000);
      tick();
      chk("b2b_consumed", 32'(a_out_valid), 32'd0);

      // Full-scale samples: accumulator must not wrap
      for (int i = 0; i < 4; i++) send_a(29'h1FFFFFFF);
      a_valid = 1'b0;
      chk("max_valid", 32'(a_out_valid), 32'd1);
      chk("max_mean", 32'(a_mean), 32'h1FFFFFFF);
      chk("max_peak", 32'(a_peak), 32'h1FFFFFFF);
      tick();

      // clr discards a partial window and blocks the sample on that cycle
      send_a(29'h5000000);
      send_a(29'h5000000);
      a_clr   = 1'b1;
      a_valid = 1'b1;
      a_data  = 29'h5000000;
      #1;
      chk("clr_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      a_clr = 1'b0;
      for (int i = 0; i < 3; i++) send_a(29'h1000000);
      chk("clr_partial", 32'(a_out_valid), 32'd0);
      send_a(29'h1000000);
      a_valid = 1'b0;
      chk("clr_valid", 32'(a_out_valid), 32'd1);
      chk("clr_mean", 32'(a_mean), 32'h1000000);
      chk("clr_peak", 32'(a_peak), 32'h1000000);
      tick();

      // rst mid-window clears everything, including the stale result register
      for (int i = 0; i < 3; i++) send_a(29'h3000000);
      a_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst2_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      rst = 1'b0;
      chk("rst2_valid", 32'(a_out_valid), 32'd0);
      chk("rst2_mean", 32'(a_mean), 32'd0);
      chk("rst2_peak", 32'(a_peak), 32'd0);
      for (int i = 0; i < 4; i++) send_a(29'h2000000);
      a_valid = 1'b0;
      chk("post_rst_valid", 32'(a_out_valid), 32'd1);
      chk("post_rst_mean", 32'(a_mean), 32'h2000000);
      chk("post_rst_peak", 32'(a_peak), 32'h2000000);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
